stage_if: RTL

- Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the decode-stage hazard logic and consumes its load_stall, mop_stall and flush outputs.
- Owns the fetch PC and drives a synchronous instruction memory with 1-cycle read latency.
- Contains a one-entry hold buffer so the instruction presented to ID stays correct across multi-cycle stalls.
- Keeps saturating stall/flush event counters for performance debug.

---
 rtl/stage_if.sv | 100 ++++++++++
 1 files changed

// File: rtl/stage_if.sv
// Instruction-fetch stage with IF/ID register, one-entry hold buffer for
// multi-cycle stalls, and saturating stall/flush event counters.
module stage_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_stall,
    input  logic             mop_stall,
    input  logic             flush,
    input  logic [31:0]      br_addr,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_inst,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic             stall;
    logic [31:0]      pc_f_q, pc_f_d;
    logic [31:0]      id_pc_q, id_pc_d;
    logic             id_valid_q, id_valid_d;
    logic [31:0]      hold_inst_q, hold_inst_d;
    logic             hold_valid_q, hold_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    assign stall = load_stall | mop_stall;

    // Next-state: flush beats stall beats advance.
    always_comb begin
        pc_f_d       = pc_f_q;
        id_pc_d      = id_pc_q;
        id_valid_d   = id_valid_q;
        hold_inst_d  = hold_inst_q;
        hold_valid_d = hold_valid_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (flush) begin
            // Redirect; ID becomes a bubble, id_pc is left as-is.
            pc_f_d       = br_addr;
            id_valid_d   = 1'b0;
            hold_valid_d = 1'b0;
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
        end else if (stall) begin
            // First stall edge latches the ID instruction before the memory
            // output switches to mem[pc_f]; later stall edges keep it.
            if (!hold_valid_q) begin
                hold_inst_d  = imem_rdata;
                hold_valid_d = id_valid_q;
            end
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
            pc_f_d       = pc_f_q + 32'd4;
            id_pc_d      = pc_f_q;
            id_valid_d   = 1'b1;
            hold_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_f_q       <= RESET_PC;
            id_pc_q      <= 32'h0;
            id_valid_q   <= 1'b0;
            hold_inst_q  <= 32'h0;
            hold_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            pc_f_q       <= pc_f_d;
            id_pc_q      <= id_pc_d;
            id_valid_q   <= id_valid_d;
            hold_inst_q  <= hold_inst_d;
            hold_valid_q <= hold_valid_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // ID instruction source: hold buffer, then live memory, else NOP.
    always_comb begin
        if_id_inst = NOP;
        if (hold_valid_q)    if_id_inst = hold_inst_q;
        else if (id_valid_q) if_id_inst = imem_rdata;
    end

    assign imem_addr   = pc_f_q;
    assign if_id_pc    = id_pc_q;
    assign if_id_valid = id_valid_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule
